// File: rtl/nand_gate_test_sequencer_if.sv
// Handshake and result bundle between the NAND-XNOR self-test sequencer and its environment.
interface nand_gate_test_sequencer_if;
  logic       i_start;
  logic       i_abort;
  logic       i_f;
  logic       o_a;
  logic       o_b;
  logic       o_busy;
  logic       o_done;
  logic       o_pass;
  logic [3:0] o_table;
  logic [3:0] o_fail_mask;
  logic [7:0] o_err_cnt;

  // Sequencer side.
  modport slave (
    input  i_start, i_abort, i_f,
    output o_a, o_b, o_busy, o_done, o_pass, o_table, o_fail_mask, o_err_cnt
  );

  // Environment / bench side.
  modport master (
    output i_start, i_abort, i_f,
    input  o_a, o_b, o_busy, o_done, o_pass, o_table, o_fail_mask, o_err_cnt
  );
endinterface

// File: rtl/nand_gate_test_sequencer.sv
// Walks gate inputs through 00,01,10,11, samples f after SETTLE cycles each, then
// publishes the truth table, mismatch mask, pass flag and a saturating error count.
module nand_gate_test_sequencer #(
  parameter int unsigned SETTLE = 2,
  parameter logic [3:0]  EXPECT = 4'b1001
) (
  input logic                        clk,
  input logic                        rst_n,
  nand_gate_test_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

  localparam logic [3:0] SettleLast = 4'(SETTLE - 1);

  state_e     r_state;
  logic [1:0] r_idx;
  logic [3:0] r_cnt;
  logic [3:0] r_shadow;
  logic       r_a;
  logic       r_b;
  logic       r_busy;
  logic       r_done;
  logic       r_pass;
  logic [3:0] r_table;
  logic [3:0] r_fail_mask;
  logic [7:0] r_err_cnt;

  logic [3:0] w_mism;
  logic [2:0] w_pop;
  logic [8:0] w_sum;
  logic [7:0] w_err_next;
  logic [1:0] w_idx_inc;

  // Mismatch bits of the finished run and the saturated error total they produce.
  always_comb begin
    w_mism     = r_shadow ^ EXPECT;
    w_pop      = {2'b00, w_mism[0]} + {2'b00, w_mism[1]} + {2'b00, w_mism[2]} +
                 {2'b00, w_mism[3]};
    w_sum      = {1'b0, r_err_cnt} + {6'b000000, w_pop};
    w_err_next = w_sum[8] ? 8'hFF : w_sum[7:0];
    w_idx_inc  = r_idx + 2'd1;
  end

  // Sequencer FSM with registered outputs; abort beats both start and the result update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_idx       <= 2'd0;
      r_cnt       <= 4'd0;
      r_shadow    <= 4'd0;
      r_a         <= 1'b0;
      r_b         <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_pass      <= 1'b0;
      r_table     <= 4'd0;
      r_fail_mask <= 4'd0;
      r_err_cnt   <= 8'd0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (!bus.i_abort && bus.i_start) begin
            r_state  <= StApply;
            r_idx    <= 2'd0;
            r_cnt    <= 4'd0;
            r_shadow <= 4'd0;
            r_a      <= 1'b0;
            r_b      <= 1'b0;
            r_busy   <= 1'b1;
          end
        end
        StApply: begin
          if (bus.i_abort) begin
            r_state <= StIdle;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_busy  <= 1'b0;
          end else if (r_cnt == SettleLast) begin
            r_shadow[r_idx] <= bus.i_f;
            r_cnt           <= 4'd0;
            if (r_idx == 2'd3) begin
              // a/b already sit at 11 and stay there through the done cycle.
              r_state <= StDone;
              r_done  <= 1'b1;
            end else begin
              r_idx <= w_idx_inc;
              r_a   <= w_idx_inc[1];
              r_b   <= w_idx_inc[0];
            end
          end else begin
            r_cnt <= r_cnt + 4'd1;
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
          if (!bus.i_abort) begin
            r_table     <= r_shadow;
            r_fail_mask <= w_mism;
            r_pass      <= (r_shadow == EXPECT);
            r_err_cnt   <= w_err_next;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_a     <= 1'b0;
          r_b     <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_a         = r_a;
  assign bus.o_b         = r_b;
  assign bus.o_busy      = r_busy;
  assign bus.o_done      = r_done;
  assign bus.o_pass      = r_pass;
  assign bus.o_table     = r_table;
  assign bus.o_fail_mask = r_fail_mask;
  assign bus.o_err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_nand_gate_test_sequencer.sv
// Bench for nand_gate_test_sequencer: run-level reference model compared every cycle, plus
// directed scenarios with literal expectations.
module tb_nand_gate_test_sequencer;

  localparam int         S   = 2;
  localparam logic [3:0] EXP = 4'b1001;

  logic clk;
  logic rst_n;
  logic r_start;
  logic r_abort;
  int   mode;       // 0 xnor, 1 stuck-at-0, 2 xor, 3 random truth table
  logic [3:0] tt;

  int checks = 0;
  int errors = 0;

  nand_gate_test_sequencer_if bus ();

  nand_gate_test_sequencer #(
    .SETTLE (S),
    .EXPECT (EXP)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  function automatic logic gate(input int m, input logic [3:0] t, input logic [1:0] ab);
    case (m)
      0:       return (ab == 2'b00) || (ab == 2'b11);
      1:       return 1'b0;
      2:       return (ab == 2'b01) || (ab == 2'b10);
      default: return t[ab];
    endcase
  endfunction

  assign bus.i_start = r_start;
  assign bus.i_abort = r_abort;
  assign bus.i_f     = gate(mode, tt, {bus.o_a, bus.o_b});

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the run counted in cycles since the start edge.
  bit         m_run;
  int         m_t;
  logic [3:0] m_sh;
  logic [3:0] m_table;
  logic [3:0] m_mask;
  logic       m_pass;
  int         m_err;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run = 0; m_t = 0; m_sh = 0; m_table = 0; m_mask = 0; m_pass = 0; m_err = 0;
    end else if (!m_run) begin
      if (!r_abort && r_start) begin
        m_run = 1; m_t = 1; m_sh = 4'd0;
      end
    end else if (r_abort) begin
      m_run = 0;
    end else begin
      if (m_t <= 4 * S && (m_t % S) == 0) m_sh[m_t / S - 1] = gate(mode, tt, 2'(m_t / S - 1));
      if (m_t == 4 * S + 1) begin
        m_table = m_sh;
        m_mask  = m_sh ^ EXP;
        m_pass  = (m_sh == EXP);
        m_err   = m_err + $countones(m_sh ^ EXP);
        if (m_err > 255) m_err = 255;
        m_run   = 0;
      end else begin
        m_t++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      int ab;
      ab = !m_run ? 0 : (m_t <= 4 * S) ? (m_t - 1) / S : 3;
      chk("ab", int'({bus.o_a, bus.o_b}), ab);
      chk("busy", int'(bus.o_busy), int'(m_run));
      chk("done", int'(bus.o_done), int'(m_run && m_t == 4 * S + 1));
      chk("pass", int'(bus.o_pass), int'(m_pass));
      chk("table", int'(bus.o_table), int'(m_table));
      chk("fail_mask", int'(bus.o_fail_mask), int'(m_mask));
      chk("err_cnt", int'(bus.o_err_cnt), m_err);
    end
  end

  task automatic do_reset();
    rst_n = 1'b0;
    #12;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Pulse (or hold) start, wait for done; returns cycles from the start edge to done.
  task automatic run(input bit hold, output int n);
    r_start = 1'b1;
    @(negedge clk);
    n = 1;
    if (!hold) r_start = 1'b0;
    while (!bus.o_done && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!bus.o_done) chk("done_timeout", 0, 1);
  endtask

  initial begin
    int n;
    r_start = 1'b0; r_abort = 1'b0; mode = 0; tt = 4'd0;
    rst_n = 1'b0;
    #1;
    chk("rst_busy", int'(bus.o_busy), 0);
    chk("rst_err", int'(bus.o_err_cnt), 0);
    chk("rst_table", int'(bus.o_table), 0);
    do_reset();

    // XNOR gate: passing run with done in cycle 9.
    mode = 0;
    run(0, n);
    chk("t1_latency", n, 9);
    @(negedge clk);
    chk("t1_table", int'(bus.o_table), 4'b1001);
    chk("t1_pass", int'(bus.o_pass), 1);
    chk("t1_mask", int'(bus.o_fail_mask), 0);
    chk("t1_err", int'(bus.o_err_cnt), 0);
    chk("t1_busy_low", int'(bus.o_busy), 0);

    // Stuck-at-0: two runs, two mismatches each.
    mode = 1;
    run(0, n);
    @(negedge clk);
    chk("t2_table", int'(bus.o_table), 0);
    chk("t2_mask", int'(bus.o_fail_mask), 4'b1001);
    chk("t2_pass", int'(bus.o_pass), 0);
    chk("t2_err1", int'(bus.o_err_cnt), 2);
    run(0, n);
    @(negedge clk);
    chk("t2_err2", int'(bus.o_err_cnt), 4);

    // XOR gate from a clean count: saturation at run 64.
    do_reset();
    mode = 2;
    for (int i = 1; i <= 65; i++) begin
      run(0, n);
      @(negedge clk);
      if (i == 1) chk("t3_mask", int'(bus.o_fail_mask), 4'b1111);
      if (i == 63) chk("t3_err63", int'(bus.o_err_cnt), 252);
      if (i == 64) chk("t3_err64", int'(bus.o_err_cnt), 255);
      if (i == 65) chk("t3_err65", int'(bus.o_err_cnt), 255);
    end

    // Start held high: one idle cycle between runs.
    do_reset();
    mode = 0;
    run(1, n);
    chk("t4_latency", n, 9);
    @(negedge clk);
    chk("t4_idle_busy", int'(bus.o_busy), 0);
    chk("t4_idle_ab", int'({bus.o_a, bus.o_b}), 0);
    @(negedge clk);
    chk("t4_relaunch", int'(bus.o_busy), 1);
    r_start = 1'b0;
    run(0, n);
    @(negedge clk);

    // Abort while {a,b}=10 after a passing run.
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    n = 0;
    while ({bus.o_a, bus.o_b} != 2'b10 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t5_reach10", int'({bus.o_a, bus.o_b}), 2);
    r_abort = 1'b1;
    @(negedge clk);
    r_abort = 1'b0;
    chk("t5_busy", int'(bus.o_busy), 0);
    chk("t5_ab", int'({bus.o_a, bus.o_b}), 0);
    chk("t5_table", int'(bus.o_table), 4'b1001);
    chk("t5_pass", int'(bus.o_pass), 1);
    r_abort = 1'b1; r_start = 1'b1;
    @(negedge clk);
    r_abort = 1'b0; r_start = 1'b0;
    chk("t5_abort_start", int'(bus.o_busy), 0);
    @(negedge clk);

    // Reset mid-APPLY after err_cnt reached 2.
    mode = 1;
    run(0, n);
    @(negedge clk);
    chk("t6_err", int'(bus.o_err_cnt), 2);
    r_start = 1'b1;
    @(negedge clk);
    r_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("t6_rst_busy", int'(bus.o_busy), 0);
    chk("t6_rst_ab", int'({bus.o_a, bus.o_b}), 0);
    chk("t6_rst_err", int'(bus.o_err_cnt), 0);
    chk("t6_rst_mask", int'(bus.o_fail_mask), 0);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    run(0, n);
    chk("t6_latency", n, 9);
    @(negedge clk);

    // Random starts, aborts and gate truth tables against the model.
    mode = 3;
    for (int i = 0; i < 600; i++) begin
      r_start = ($urandom_range(0, 3) == 0);
      r_abort = ($urandom_range(0, 19) == 0);
      if (!bus.o_busy) tt = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    r_start = 1'b0; r_abort = 1'b0;
    repeat (12) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/nand_gate_test_sequencer.md
# nand_gate_test_sequencer

Self-test controller for the two-input NAND-built XNOR gate stage in the combinational-circuit lab designs. On a start pulse it drives the gate inputs A and B through all four combinations. It waits a programmable settle time for each combination, samples the gate output and assembles a 4-bit truth table. It then compares the table with the expected function and reports pass/fail plus a saturating cumulative error count.

## Interface
- SETTLE, 2: cycles each input combination is held before f is sampled; legal range 1..15.
- EXPECT, 4'b1001: expected truth table; bit index = {A,B}. The default is XNOR.

- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  begin a run; sampled only in IDLE.
- abort  input  1  synchronous abort; returns to IDLE without done.
- f  input  1  output of the gate under test. It is combinational from a/b.
- a  output  1  gate input A.
- b  output  1  gate input B.
- busy  output  1  high while a run is in progress.
- done  output  1  one-cycle pulse when a run completes.
- pass  output  1  last completed run matched EXPECT.
- table  output  4  last completed run's sampled truth table; bit {a,b} = f.
- fail_mask  output  4  table XOR EXPECT for the last completed run.
- err_cnt  output  8  cumulative mismatched bits over all runs; saturates at 255.

## Operation
- States: IDLE, APPLY, DONE.
- IDLE
  - a=b=0, busy=0.
  - start=1 at a clock edge: go to APPLY, idx=0, wait counter=0, shadow table cleared.
- APPLY
  - {a,b}=idx[1:0], busy=1.
  - The wait counter increments each cycle.
  - When counter==SETTLE-1, f is captured into shadow[idx] at that edge and the counter is cleared.
  - If idx==3, go to DONE. Otherwise idx increments.
- DONE (one cycle)
  - done=1 and busy=1.
  - a/b hold 11.
  - At the exiting edge:
    - table<=shadow
    - fail_mask<=shadow^EXPECT
    - pass<=(shadow==EXPECT)
    - err_cnt<=min(255, err_cnt+popcount(shadow^EXPECT))
  - Next state is IDLE.
- abort=1 in APPLY or DONE: go to IDLE at that edge.
  - done does not pulse.
  - table, fail_mask, pass and err_cnt are unchanged.
  - abort takes priority over the DONE-state update.
  - abort in IDLE has no effect and takes priority over start.
- start while busy is ignored.
  - start held high re-launches a run after exactly one IDLE cycle.
- Width rules:
  - idx is 2 bits.
  - The wait counter is 4 bits.
  - The popcount is a 3-bit sum, zero-extended before the saturating 8-bit add.

## Timing
- Reset (async assert, sync to clk on release):
  - state IDLE.
  - a=b=busy=done=pass=0.
  - table=fail_mask=0, err_cnt=0, shadow and counters 0.
- Reset mid-run aborts immediately; nothing is retained.
- start sampled at edge E0:
  - busy rises after E0.
  - Combination k is driven during cycles k*SETTLE+1 .. (k+1)*SETTLE after E0.
  - f is sampled at edge E((k+1)*SETTLE).
- done is high in cycle 4*SETTLE+1 after E0 (cycle 9 for SETTLE=2).
- Results are visible starting the cycle after done. busy falls in the same cycle.
- All outputs are registered. f must be stable within SETTLE cycles of an a/b change.

## Test plan
1. SETTLE=2, f modeled as XNOR(a,b), start pulse at E0:
   - a,b sequence 00,01,10,11, each held 2 cycles.
   - done in cycle 9.
   - After done: table=1001, pass=1, fail_mask=0000, err_cnt=0.
2. f stuck at 0, two consecutive runs:
   - After run 1: table=0000, fail_mask=1001, pass=0, err_cnt=2.
   - After run 2: err_cnt=4.
3. f modeled as XOR (inverted), 64 runs:
   - After each run: fail_mask=1111.
   - err_cnt steps by 4 and reaches 255 on run 64.
   - A 65th run leaves err_cnt=255.
4. Run with start held high throughout:
   - Extra start pulses while busy have no effect.
   - A second run begins after a single IDLE cycle with a=b=0.
5. abort asserted while {a,b}=10, after one passing run:
   - Next cycle: IDLE, a=b=0, busy=0.
   - No done pulse; table=1001 and pass=1 retained.
   - abort and start together in IDLE: stays IDLE.
6. rst_n pulsed low mid-APPLY after err_cnt=2:
   - All outputs are 0 immediately and asynchronously, with err_cnt=0.
   - A subsequent start produces a normal 4*SETTLE+1 run.
